// File: rtl/branch_flag_unit_pkg.sv
// Shared definitions for the branch/flag unit: datapath width, condition codes,
// flag bit positions and FSM state encoding.
package branch_flag_unit_pkg;

   localparam int DSIZE = 16;

   localparam logic [2:0] COND_EQ = 3'b000;
   localparam logic [2:0] COND_NE = 3'b001;
   localparam logic [2:0] COND_GT = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_LE = 3'b101;
   localparam logic [2:0] COND_OV = 3'b110;
   localparam logic [2:0] COND_AL = 3'b111;

   localparam int FLAG_Z = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolver: decides taken/not-taken from the
// effective {n, v, z} flags and a 3-bit condition code.
module branch_cond_eval (
   input  logic [2:0] flags,
   input  logic [2:0] cond,
   output logic       taken
);
   import branch_flag_unit_pkg::*;

   logic n, v, z;

   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];
   assign z = flags[FLAG_Z];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = z;
         COND_NE: taken = !z;
         COND_GT: taken = !z && !n;
         COND_LT: taken = n;
         COND_GE: taken = !n;
         COND_LE: taken = z || n;
         COND_OV: taken = v;
         COND_AL: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_flag_unit.sv
// Architectural flag register plus conditional-branch resolution with registered
// PC redirect and multi-cycle flush. Optional BRANCH_STATS_EN adds branch counters.
module branch_flag_unit #(
   parameter int FLUSH_CYCLES = 2,
   parameter int DSIZE        = branch_flag_unit_pkg::DSIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_flag_we,
   input  logic [2:0]       alu_flag,
   input  logic             br_valid,
   input  logic [2:0]       br_cond,
   input  logic [DSIZE-1:0] br_pc,
   input  logic [7:0]       br_offset,
   output logic [2:0]       flag,
   output logic             redirect,
   output logic [DSIZE-1:0] redirect_pc,
   output logic             flush,
   output logic             busy
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]      taken_cnt,
   output logic [15:0]      nottaken_cnt
`endif
);
   import branch_flag_unit_pkg::*;

   function automatic logic [15:0] sat_inc(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   state_t            state;
   logic [2:0]        cnt;
   logic              flag_wr;
   logic [2:0]        eff_flag;
   logic              taken;
   logic              br_eval;
   logic signed [DSIZE-1:0] off_ext;
   logic [DSIZE-1:0]  target;

   // A flag-setting op retiring this cycle is forwarded to the branch in ID.
   assign flag_wr  = ex_valid && ex_flag_we;
   assign eff_flag = flag_wr ? alu_flag : flag;
   assign br_eval  = br_valid && (state == ST_IDLE);

   branch_cond_eval u_cond (
      .flags (eff_flag),
      .cond  (br_cond),
      .taken (taken)
   );

   // Target arithmetic wraps modulo 2^DSIZE by construction.
   assign off_ext = {{(DSIZE-8){br_offset[7]}}, br_offset};
   assign target  = br_pc + DSIZE'(1) + off_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= 3'd0;
         flag        <= 3'b000;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         flush       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         redirect <= 1'b0;
         if (flag_wr)
            flag <= alu_flag;
         case (state)
            ST_IDLE: begin
               if (br_eval && taken) begin
                  state       <= ST_FLUSH;
                  cnt         <= 3'(FLUSH_CYCLES - 1);
                  redirect    <= 1'b1;
                  redirect_pc <= target;
                  flush       <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (cnt == 3'd0) begin
                  state <= ST_IDLE;
                  flush <= 1'b0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt    <= 16'd0;
         nottaken_cnt <= 16'd0;
      end else if (br_eval) begin
         if (taken)
            taken_cnt <= sat_inc(taken_cnt);
         else
            nottaken_cnt <= sat_inc(nottaken_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: expected redirect targets are queued at
// issue and matched by a monitor whenever redirect is seen.
module tb_branch_flag_unit;
   import branch_flag_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_flag_we;
   logic [2:0]  alu_flag;
   logic        br_valid;
   logic [2:0]  br_cond;
   logic [15:0] br_pc;
   logic [7:0]  br_offset;
   logic [2:0]  flag;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        flush, busy;
`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt, nottaken_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   branch_flag_unit #(.FLUSH_CYCLES(2), .DSIZE(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_flag_we  (ex_flag_we),
      .alu_flag    (alu_flag),
      .br_valid    (br_valid),
      .br_cond     (br_cond),
      .br_pc       (br_pc),
      .br_offset   (br_offset),
      .flag        (flag),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .flush       (flush),
      .busy        (busy)
`ifdef BRANCH_STATS_EN
      ,
      .taken_cnt   (taken_cnt),
      .nottaken_cnt(nottaken_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // Monitor: each redirect pulse consumes one expected target.
   always @(negedge clk) begin
      if (redirect) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_redirect: got redirect_pc=%h, expected no redirect", redirect_pc);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (redirect_pc !== e) begin
               errors++;
               $display("FAIL redirect_pc: got %h, expected %h", redirect_pc, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      ex_valid = 0; ex_flag_we = 0; alu_flag = 3'b000;
      br_valid = 0; br_cond = 3'b000; br_pc = 16'h0; br_offset = 8'h0;
   endtask

   task automatic set_flag(input logic [2:0] f);
      ex_valid = 1; ex_flag_we = 1; alu_flag = f;
      tick();
      idle_inputs();
   endtask

   // Issue one evaluated branch from IDLE and let any flush drain.
   task automatic branch(input logic [2:0] c, input logic [15:0] pc,
                         input logic [7:0] off, input logic exp_tk, input logic [15:0] tgt);
      br_valid = 1; br_cond = c; br_pc = pc; br_offset = off;
      if (exp_tk) exp_q.push_back(tgt);
      tick();
      idle_inputs();
      chk($sformatf("flush_after_cond%0d", c), {31'd0, flush}, {31'd0, exp_tk});
      tick(); tick();
   endtask

   typedef struct { logic [2:0] f; logic [2:0] c; logic tk; } cvec_t;
   cvec_t cv[$];

   initial begin
      idle_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      chk("rst_flag", {29'd0, flag}, 32'd0);
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_redirect_pc", {16'd0, redirect_pc}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      set_flag(3'b001);
      chk("flag_write", {29'd0, flag}, 32'd1);
      ex_valid = 0; ex_flag_we = 1; alu_flag = 3'b110;
      tick(); idle_inputs();
      chk("flag_no_write_squashed", {29'd0, flag}, 32'd1);
      set_flag(3'b000);
      chk("flag_clear", {29'd0, flag}, 32'd0);

      // EQ with z=0: not taken
      br_valid = 1; br_cond = COND_EQ; br_pc = 16'h0010; br_offset = 8'hFC;
      tick(); idle_inputs();
      chk("eq_nt_flush", {31'd0, flush}, 32'd0);

      // Same branch with forwarded z=1: taken, target 0x000D
      ex_valid = 1; ex_flag_we = 1; alu_flag = 3'b001;
      br_valid = 1; br_cond = COND_EQ; br_pc = 16'h0010; br_offset = 8'hFC;
      exp_q.push_back(16'h000D);
      tick(); idle_inputs();
      chk("fwd_redirect", {31'd0, redirect}, 32'd1);
      chk("fwd_flush_t1", {31'd0, flush}, 32'd1);
      chk("fwd_busy_t1", {31'd0, busy}, 32'd1);
      chk("fwd_flag_t1", {29'd0, flag}, 32'd1);
      ex_valid = 1; ex_flag_we = 1; alu_flag = 3'b100;
      tick(); idle_inputs();
      chk("fwd_redirect_t2", {31'd0, redirect}, 32'd0);
      chk("fwd_flush_t2", {31'd0, flush}, 32'd1);
      chk("flag_write_in_flush", {29'd0, flag}, 32'd4);
      tick();
      chk("fwd_flush_t3", {31'd0, flush}, 32'd0);
      chk("fwd_busy_t3", {31'd0, busy}, 32'd0);

      // PC wrap
      branch(COND_AL, 16'hFFFF, 8'h00, 1'b1, 16'h0000);

      // Back-to-back: branches at T+1, T+2 squashed, T+3 evaluated
      br_valid = 1; br_cond = COND_AL; br_pc = 16'h0100; br_offset = 8'h05;
      exp_q.push_back(16'h0106);
      tick();
      br_pc = 16'h0200; br_offset = 8'h00;
      tick();
      chk("b2b_flush_t2", {31'd0, flush}, 32'd1);
      tick();
      chk("b2b_flush_t3", {31'd0, flush}, 32'd0);
      br_pc = 16'h0300; br_offset = 8'h80;
      exp_q.push_back(16'h0281);
      tick(); idle_inputs();
      chk("b2b_third_flush", {31'd0, flush}, 32'd1);
      tick(); tick();

      // Condition table
      cv.push_back('{3'b000, COND_NE, 1'b1});
      cv.push_back('{3'b001, COND_NE, 1'b0});
      cv.push_back('{3'b000, COND_GT, 1'b1});
      cv.push_back('{3'b100, COND_GT, 1'b0});
      cv.push_back('{3'b001, COND_GT, 1'b0});
      cv.push_back('{3'b100, COND_LT, 1'b1});
      cv.push_back('{3'b000, COND_LT, 1'b0});
      cv.push_back('{3'b000, COND_GE, 1'b1});
      cv.push_back('{3'b100, COND_GE, 1'b0});
      cv.push_back('{3'b001, COND_LE, 1'b1});
      cv.push_back('{3'b100, COND_LE, 1'b1});
      cv.push_back('{3'b000, COND_LE, 1'b0});
      cv.push_back('{3'b010, COND_OV, 1'b1});
      cv.push_back('{3'b000, COND_OV, 1'b0});
      cv.push_back('{3'b001, COND_EQ, 1'b1});
      foreach (cv[i]) begin
         set_flag(cv[i].f);
         branch(cv[i].c, 16'h0040, 8'h01, cv[i].tk, 16'h0042);
      end

      // Reset mid-flush dominates same-cycle branch and flag write
      ex_valid = 1; ex_flag_we = 1; alu_flag = 3'b110;
      br_valid = 1; br_cond = COND_AL; br_pc = 16'h0050; br_offset = 8'h00;
      exp_q.push_back(16'h0051);
      tick();
      rst = 1; alu_flag = 3'b111;
      tick();
      rst = 0; idle_inputs();
      chk("rst_mid_flush", {31'd0, flush}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_flag", {29'd0, flag}, 32'd0);
      chk("rst_mid_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_mid_redirect_pc", {16'd0, redirect_pc}, 32'd0);
      tick();

`ifdef BRANCH_STATS_EN
      rst = 1; tick(); rst = 0;
      chk("stats_rst_taken", {16'd0, taken_cnt}, 32'd0);
      branch(COND_AL, 16'h0000, 8'h00, 1'b1, 16'h0001);
      branch(COND_AL, 16'h0000, 8'h01, 1'b1, 16'h0002);
      branch(COND_EQ, 16'h0000, 8'h00, 1'b0, 16'h0000);
      // taken with one squashed branch in its flush window
      br_valid = 1; br_cond = COND_AL; br_pc = 16'h0010; br_offset = 8'h00;
      exp_q.push_back(16'h0011);
      tick();
      tick(); idle_inputs();
      tick();
      branch(COND_LT, 16'h0000, 8'h00, 1'b0, 16'h0000);
      chk("stats_taken", {16'd0, taken_cnt}, 32'd3);
      chk("stats_nottaken", {16'd0, nottaken_cnt}, 32'd2);
      br_valid = 1; br_cond = COND_NE; br_pc = 16'h0; br_offset = 8'h0;
      set_flag(3'b001);
      br_valid = 1; br_cond = COND_EQ - 3'd0 + 3'd1;
      for (int k = 0; k < 65540; k++) tick();
      idle_inputs();
      tick();
      chk("stats_nottaken_sat", {16'd0, nottaken_cnt}, 32'h0000FFFF);
      chk("stats_taken_hold", {16'd0, taken_cnt}, 32'd3);
`endif

      tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
